lighthouse_pulse_frontend: RTL and testbench

Upstream conditioning stage for the DarkRoom lighthouse decoder. It takes one raw TS3633 envelope line and synchronises and deglitches it. Each complete high pulse is timestamped against the shared 1 MHz µs timer and classified as a sweep hit, a sync pulse with its axis/data/skip bits decoded, or invalid. One pulse record is presented per pulse on a valid/ready handshake to the per-sensor decoder.

---
 rtl/lighthouse_pkg.sv | 44 ++++
 rtl/lighthouse_pulse_frontend_if.sv | 25 ++
 rtl/lh_deglitch.sv | 75 +++++++
 rtl/lighthouse_pulse_frontend.sv | 166 ++++++++++++++++
 tb/tb_lighthouse_pulse_frontend.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/lighthouse_pkg.sv
// Shared types and constants for the lighthouse pulse front end.
// Optional LH_PULSE_STATS_EN build adds per-class record counters to the top.
package lighthouse_pkg;

    localparam logic [1:0] PC_SWEEP   = 2'd0;
    localparam logic [1:0] PC_SYNC    = 2'd1;
    localparam logic [1:0] PC_INVALID = 2'd2;

    localparam int unsigned SYNC_MIN_US    = 57;
    localparam int unsigned SYNC_MAX_US    = 140;
    localparam int unsigned SYNC_BIN_COUNT = 9;

    // Element 0 is the lowest edge (57), element 8 the exclusive upper edge (140).
    localparam logic [SYNC_BIN_COUNT-1:0][15:0] SYNC_BIN_EDGES = {
        16'd140, 16'd130, 16'd120, 16'd109, 16'd99,
        16'd88,  16'd78,  16'd67,  16'd57
    };

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_CLASSIFY = 2'd2
    } lh_state_e;

    typedef struct packed {
        logic [31:0] start;
        logic [15:0] width;
        logic [1:0]  cls;
        logic        axis;
        logic        data;
        logic        skip;
    } pulse_rec_t;

    // Sync bin index for a width already known to lie inside [57,140).
    function automatic logic [2:0] sync_bin(input logic [15:0] w);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w >= SYNC_BIN_EDGES[i]) n = n + 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/lighthouse_pulse_frontend_if.sv
// Pulse record valid/ready bus between the front end and the per-sensor decoder.
interface lighthouse_pulse_frontend_if;

    logic        pulse_valid;
    logic        pulse_ready;
    logic [31:0] pulse_start;
    logic [15:0] pulse_width;
    logic [1:0]  pulse_class;
    logic        pulse_axis;
    logic        pulse_data;
    logic        pulse_skip;

    modport master (
        output pulse_valid, pulse_start, pulse_width, pulse_class,
               pulse_axis, pulse_data, pulse_skip,
        input  pulse_ready
    );

    modport slave (
        input  pulse_valid, pulse_start, pulse_width, pulse_class,
               pulse_axis, pulse_data, pulse_skip,
        output pulse_ready
    );

endinterface

// File: rtl/lh_deglitch.sv
// Synchroniser, glitch filter and post-reset arming for the raw sensor line.
// Emits the filtered level plus registered one-cycle rise/fall strobes.
module lh_deglitch #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned GLITCH_CYCLES = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sensor_signal,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       low_cnt_q;
    logic                   armed_q;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_signal};
        end
    end

    // Level follows the synchronised input only after a full run of differing samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
            cnt_q <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_bit != level) begin
                if (cnt_q == CNT_LAST) begin
                    level <= sync_bit;
                    cnt_q <= '0;
                    rise  <= sync_bit & armed_q;
                    fall  <= ~sync_bit;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Arm once the line has been seen low for a whole window, so a pulse in
    // progress at reset release never produces a record.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            low_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            if (!sync_bit && !level) begin
                if (low_cnt_q == CNT_LAST) armed_q <= 1'b1;
                else                       low_cnt_q <= low_cnt_q + CNT_W'(1);
            end else begin
                low_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/lighthouse_pulse_frontend.sv
// Lighthouse pulse front end: deglitch, timestamp, classify, hand off one record per pulse.
// Define LH_PULSE_STATS_EN to add sync_count/sweep_count/invalid_count outputs.
module lighthouse_pulse_frontend
    import lighthouse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned GLITCH_CYCLES = 8,
    parameter int unsigned SWEEP_MAX_US  = 50
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sensor_signal,
    input  logic [31:0] timer,
    lighthouse_pulse_frontend_if.master bus,
    output logic [7:0]  drop_count
`ifdef LH_PULSE_STATS_EN
    ,
    output logic [15:0] sync_count,
    output logic [15:0] sweep_count,
    output logic [15:0] invalid_count
`endif
);

    logic level;
    logic rise;
    logic fall;

    lh_deglitch #(
        .SYNC_STAGES   (SYNC_STAGES),
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_deglitch (
        .clock         (clock),
        .reset_n       (reset_n),
        .sensor_signal (sensor_signal),
        .level         (level),
        .rise          (rise),
        .fall          (fall)
    );

    lh_state_e   state_q, state_d;
    logic [31:0] start_q, start_d;
    logic [31:0] raw_q,   raw_d;
    logic        load_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            raw_q   <= raw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        raw_d   = raw_q;
        load_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise && level) begin
                    start_d = timer;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // Modulo subtraction keeps the width right across the timer wrap.
                if (fall) begin
                    raw_d   = timer - start_q;
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                load_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [15:0] width_c;
    logic [2:0]  bin_c;
    pulse_rec_t  rec_c;

    // Saturate and classify the finished pulse.
    always_comb begin
        width_c   = (raw_q[31:16] != 16'd0) ? 16'hFFFF : raw_q[15:0];
        bin_c     = sync_bin(width_c);
        rec_c     = '0;
        rec_c.start = start_q;
        rec_c.width = width_c;
        if (32'(width_c) < SWEEP_MAX_US) begin
            rec_c.cls = PC_SWEEP;
        end else if (32'(width_c) >= SYNC_MIN_US && 32'(width_c) < SYNC_MAX_US) begin
            rec_c.cls  = PC_SYNC;
            rec_c.axis = bin_c[0];
            rec_c.data = bin_c[1];
            rec_c.skip = bin_c[2];
        end else begin
            rec_c.cls = PC_INVALID;
        end
    end

    pulse_rec_t rec_q;
    logic       valid_q;
    logic [7:0] drop_q;
    logic       accept_c;
    logic       store_c;

    assign accept_c = valid_q & bus.pulse_ready;
    assign store_c  = load_c & (~valid_q | accept_c);

    // Output holding register; a full, unaccepted slot drops the new record.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rec_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            if (store_c) begin
                rec_q   <= rec_c;
                valid_q <= 1'b1;
            end else if (accept_c) begin
                valid_q <= 1'b0;
            end
            if (load_c && !store_c && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign bus.pulse_valid = valid_q;
    assign bus.pulse_start = rec_q.start;
    assign bus.pulse_width = rec_q.width;
    assign bus.pulse_class = rec_q.cls;
    assign bus.pulse_axis  = rec_q.axis;
    assign bus.pulse_data  = rec_q.data;
    assign bus.pulse_skip  = rec_q.skip;
    assign drop_count      = drop_q;

`ifdef LH_PULSE_STATS_EN
    logic [15:0] sync_q;
    logic [15:0] sweep_q;
    logic [15:0] invalid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            sweep_q   <= '0;
            invalid_q <= '0;
        end else if (store_c) begin
            if (rec_c.cls == PC_SYNC)    sync_q    <= sync_q + 16'd1;
            if (rec_c.cls == PC_SWEEP)   sweep_q   <= sweep_q + 16'd1;
            if (rec_c.cls == PC_INVALID) invalid_q <= invalid_q + 16'd1;
        end
    end

    assign sync_count    = sync_q;
    assign sweep_count   = sweep_q;
    assign invalid_count = invalid_q;
`endif

endmodule

// File: tb/tb_lighthouse_pulse_frontend.sv
// Directed self-checking bench for lighthouse_pulse_frontend (default build).
module tb_lighthouse_pulse_frontend;
    import lighthouse_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        sensor_signal;
    logic [31:0] timer;
    logic [7:0]  drop_count;

    lighthouse_pulse_frontend_if bus ();

    lighthouse_pulse_frontend #(
        .SYNC_STAGES   (2),
        .GLITCH_CYCLES (8),
        .SWEEP_MAX_US  (50)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sensor_signal (sensor_signal),
        .timer         (timer),
        .bus           (bus.master),
        .drop_count    (drop_count)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          phase  = 0;
    bit          timer_run = 1'b1;
    pulse_rec_t  got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: record any transfer on this edge, then advance the µs timer.
    task automatic tick();
        pulse_rec_t r;
        if (bus.pulse_valid && bus.pulse_ready) begin
            r.start = bus.pulse_start;
            r.width = bus.pulse_width;
            r.cls   = bus.pulse_class;
            r.axis  = bus.pulse_axis;
            r.data  = bus.pulse_data;
            r.skip  = bus.pulse_skip;
            got_q.push_back(r);
        end
        @(posedge clock);
        #1;
        if (timer_run) begin
            if (phase == 49) begin
                phase = 0;
                timer = timer + 32'd1;
            end else begin
                phase++;
            end
        end
    endtask

    task automatic run_us(input int n);
        repeat (n * 50) tick();
    endtask

    task automatic align();
        for (int i = 0; i < 50 && phase != 0; i++) tick();
    endtask

    task automatic pulse(input int w, output logic [31:0] t0);
        align();
        t0 = timer;
        sensor_signal = 1'b1;
        run_us(w);
        sensor_signal = 1'b0;
        run_us(2);
    endtask

    task automatic expect_rec(input string tag, input logic [31:0] start, input logic [15:0] width,
                              input logic [1:0] cls, input logic [2:0] ads);
        pulse_rec_t r;
        check({tag, "_count"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() == 0) return;
        r = got_q.pop_front();
        check({tag, "_start"}, r.start, start);
        check({tag, "_width"}, 32'(r.width), 32'(width));
        check({tag, "_class"}, 32'(r.cls), 32'(cls));
        check({tag, "_ads"}, 32'({r.axis, r.data, r.skip}), 32'(ads));
        got_q.delete();
    endtask

    logic [31:0] t0;
    logic [31:0] t1;

    initial begin
        reset_n       = 1'b0;
        sensor_signal = 1'b0;
        timer         = 32'd0;
        bus.pulse_ready = 1'b1;
        repeat (5) tick();
        check("rst_valid", 32'(bus.pulse_valid), 32'd0);
        check("rst_start", bus.pulse_start, 32'd0);
        check("rst_width", 32'(bus.pulse_width), 32'd0);
        check("rst_class", 32'(bus.pulse_class), 32'd0);
        check("rst_drop",  32'(drop_count), 32'd0);
        reset_n = 1'b1;
        run_us(1);

        // Clean 10 µs sweep with latency check: valid 12 clocks after the raw fall.
        align();
        t0 = timer;
        sensor_signal = 1'b1;
        run_us(10);
        sensor_signal = 1'b0;
        repeat (11) tick();
        check("lat_early", 32'(bus.pulse_valid), 32'd0);
        tick();
        check("lat_valid", 32'(bus.pulse_valid), 32'd1);
        run_us(2);
        expect_rec("sweep10", t0, 16'd10, PC_SWEEP, 3'b000);

        pulse(63, t0);  expect_rec("sync63",  t0, 16'd63,  PC_SYNC,    3'b000);
        pulse(94, t0);  expect_rec("sync94",  t0, 16'd94,  PC_SYNC,    3'b110);
        pulse(135, t0); expect_rec("sync135", t0, 16'd135, PC_SYNC,    3'b111);
        pulse(55, t0);  expect_rec("inv55",   t0, 16'd55,  PC_INVALID, 3'b000);
        pulse(200, t0); expect_rec("inv200",  t0, 16'd200, PC_INVALID, 3'b000);

        // Short high glitch in idle, short low glitch inside a 20 µs pulse.
        align();
        sensor_signal = 1'b1;
        repeat (7) tick();
        sensor_signal = 1'b0;
        run_us(2);
        check("glitch_idle", 32'(got_q.size()), 32'd0);
        align();
        t0 = timer;
        sensor_signal = 1'b1;
        run_us(10);
        sensor_signal = 1'b0;
        repeat (7) tick();
        sensor_signal = 1'b1;
        repeat (43) tick();
        run_us(9);
        sensor_signal = 1'b0;
        run_us(2);
        expect_rec("glitch20", t0, 16'd20, PC_SWEEP, 3'b000);

        // Reset released mid-pulse: that pulse is ignored, the next one is measured.
        align();
        sensor_signal = 1'b1;
        repeat (100) tick();
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_mid_valid", 32'(bus.pulse_valid), 32'd0);
        reset_n = 1'b1;
        run_us(20);
        sensor_signal = 1'b0;
        run_us(2);
        check("rst_mid_none", 32'(got_q.size()), 32'd0);
        pulse(30, t0);
        expect_rec("after_rst30", t0, 16'd30, PC_SWEEP, 3'b000);

        // Backpressure: first record held, next two dropped.
        bus.pulse_ready = 1'b0;
        pulse(10, t1);
        pulse(10, t0);
        pulse(10, t0);
        check("bp_valid", 32'(bus.pulse_valid), 32'd1);
        check("bp_start", bus.pulse_start, t1);
        check("bp_width", 32'(bus.pulse_width), 32'd10);
        check("bp_drop",  32'(drop_count), 32'd2);
        bus.pulse_ready = 1'b1;
        tick();
        check("bp_release", 32'(bus.pulse_valid), 32'd0);
        expect_rec("bp_rec", t1, 16'd10, PC_SWEEP, 3'b000);

        // Timer wrap across 2^32.
        align();
        timer = 32'hFFFF_FFF0;
        pulse(40, t0);
        expect_rec("wrap40", 32'hFFFF_FFF0, 16'd40, PC_SWEEP, 3'b000);

        // Width beyond 16 bits saturates and is invalid.
        align();
        t0 = timer;
        sensor_signal = 1'b1;
        run_us(10);
        timer = timer + 32'd70000;
        run_us(10);
        sensor_signal = 1'b0;
        run_us(2);
        expect_rec("sat", t0, 16'hFFFF, PC_INVALID, 3'b000);

        // Stalled timer gives zero width.
        align();
        timer_run = 1'b0;
        pulse(10, t0);
        expect_rec("stall", t0, 16'd0, PC_SWEEP, 3'b000);
        timer_run = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
